// File: rtl/red_pitaya_dac_seq_pkg.sv
// Shared widths, gain scale, channel state encoding and gain ramp helpers
// for the DAC output sequencer.
package red_pitaya_dac_seq_pkg;

    localparam int DW = 14;
    localparam int GW = 10;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic        [GW:0]   gain_t;

    localparam gain_t FULL = {1'b1, {GW{1'b0}}};

    localparam logic [1:0] ST_OFF       = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_ON        = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    // A zero step means "jump to the end of the ramp" in both directions.
    function automatic gain_t gain_up(input gain_t g, input logic [GW-1:0] step);
        logic [GW+1:0] sum;
        sum = {1'b0, g} + {2'b00, step};
        if (step == '0 || sum >= {1'b0, FULL}) begin
            return FULL;
        end
        return sum[GW:0];
    endfunction

    function automatic gain_t gain_down(input gain_t g, input logic [GW-1:0] step);
        if (step == '0 || {1'b0, step} >= g) begin
            return '0;
        end
        return g - {1'b0, step};
    endfunction

endpackage

// File: rtl/red_pitaya_dac_seq_if.sv
// Control, source and DAC-side signals of the sequencer; slave is the
// sequencer itself, master is whatever drives the sources and reads the DAC side.
interface red_pitaya_dac_seq_if
    import red_pitaya_dac_seq_pkg::*;
();

    logic            dac_locked_i;
    logic [1:0]      ch_ena_i;
    logic [1:0]      ch_sel_i;
    logic [GW-1:0]   ramp_step_i;
    sample_t         src0_a_i;
    sample_t         src0_b_i;
    sample_t         src1_a_i;
    sample_t         src1_b_i;
    sample_t         dac_dat_a_o;
    sample_t         dac_dat_b_o;
    logic [1:0]      ch_on_o;
    logic [1:0]      ch_busy_o;

    modport master (
        output dac_locked_i, ch_ena_i, ch_sel_i, ramp_step_i,
               src0_a_i, src0_b_i, src1_a_i, src1_b_i,
        input  dac_dat_a_o, dac_dat_b_o, ch_on_o, ch_busy_o
    );

    modport slave (
        input  dac_locked_i, ch_ena_i, ch_sel_i, ramp_step_i,
               src0_a_i, src0_b_i, src1_a_i, src1_b_i,
        output dac_dat_a_o, dac_dat_b_o, ch_on_o, ch_busy_o
    );

endinterface

// File: rtl/red_pitaya_dac_seq_ch.sv
// One DAC channel: enable/source-switch FSM with soft gain ramp, followed by
// a two-stage select-and-scale datapath.
module red_pitaya_dac_seq_ch
    import red_pitaya_dac_seq_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_locked,
    input  logic          i_ena,
    input  logic          i_sel,
    input  logic [GW-1:0] i_step,
    input  sample_t       i_src0,
    input  sample_t       i_src1,
    output sample_t       o_dat,
    output logic          o_on,
    output logic          o_busy
);

    logic [1:0] r_state;
    gain_t      r_gain;
    logic       r_active_sel;

    logic [1:0] w_state_nxt;
    gain_t      w_gain_nxt;
    logic       w_sel_nxt;
    gain_t      w_first;
    gain_t      w_up;
    gain_t      w_dn;
    logic       w_leave;

    // Leaving OFF already applies the first ramp step, so a zero step reaches ON in one edge.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_sel_nxt   = r_active_sel;
        w_first     = gain_up('0, i_step);
        w_up        = gain_up(r_gain, i_step);
        w_dn        = gain_down(r_gain, i_step);
        w_leave     = !i_ena || (i_sel != r_active_sel);

        case (r_state)
            ST_OFF: begin
                w_gain_nxt = '0;
                if (i_ena) begin
                    w_sel_nxt   = i_sel;
                    w_gain_nxt  = w_first;
                    w_state_nxt = (w_first == FULL) ? ST_ON : ST_RAMP_UP;
                end
            end
            ST_RAMP_UP, ST_ON: begin
                if (w_leave) begin
                    w_gain_nxt  = w_dn;
                    w_state_nxt = (w_dn == '0) ? ST_OFF : ST_RAMP_DOWN;
                end else begin
                    w_gain_nxt  = w_up;
                    w_state_nxt = (w_up == FULL) ? ST_ON : ST_RAMP_UP;
                end
            end
            ST_RAMP_DOWN: begin
                w_gain_nxt  = w_dn;
                w_state_nxt = (w_dn == '0) ? ST_OFF : ST_RAMP_DOWN;
            end
            default: begin
                w_gain_nxt  = '0;
                w_state_nxt = ST_OFF;
            end
        endcase

        if (!i_locked) begin
            w_gain_nxt  = '0;
            w_state_nxt = ST_OFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_OFF;
            r_gain       <= '0;
            r_active_sel <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gain       <= w_gain_nxt;
            r_active_sel <= w_sel_nxt;
        end
    end

    sample_t                  r_x;
    gain_t                    r_g;
    sample_t                  r_out;
    logic signed [DW+GW-1:0]  w_x_ext;
    logic signed [DW+GW-1:0]  w_g_ext;
    logic signed [DW+GW-1:0]  w_prod;

    // |x*g| never exceeds 2**(DW+GW-1), so DW+GW signed bits hold the product exactly.
    assign w_x_ext = (DW+GW)'(r_x);
    assign w_g_ext = (DW+GW)'({1'b0, r_g});
    assign w_prod  = w_x_ext * w_g_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x   <= '0;
            r_g   <= '0;
            r_out <= '0;
        end else if (!i_locked) begin
            r_x   <= '0;
            r_g   <= '0;
            r_out <= '0;
        end else begin
            r_x   <= r_active_sel ? i_src1 : i_src0;
            r_g   <= r_gain;
            r_out <= sample_t'(w_prod >>> GW);
        end
    end

    assign o_dat  = r_out;
    assign o_on   = (r_state == ST_ON);
    assign o_busy = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);

endmodule

// File: rtl/red_pitaya_dac_seq.sv
// Two-channel DAC output sequencer: one independent channel instance per
// DAC output, both in the adc_clk domain.
module red_pitaya_dac_seq (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    red_pitaya_dac_seq_if.slave  bus
);

    logic [1:0] w_on;
    logic [1:0] w_busy;

    red_pitaya_dac_seq_ch u_ch_a (
        .i_clk    (adc_clk_i),
        .i_rst_n  (adc_rst_i),
        .i_locked (bus.dac_locked_i),
        .i_ena    (bus.ch_ena_i[0]),
        .i_sel    (bus.ch_sel_i[0]),
        .i_step   (bus.ramp_step_i),
        .i_src0   (bus.src0_a_i),
        .i_src1   (bus.src1_a_i),
        .o_dat    (bus.dac_dat_a_o),
        .o_on     (w_on[0]),
        .o_busy   (w_busy[0])
    );

    red_pitaya_dac_seq_ch u_ch_b (
        .i_clk    (adc_clk_i),
        .i_rst_n  (adc_rst_i),
        .i_locked (bus.dac_locked_i),
        .i_ena    (bus.ch_ena_i[1]),
        .i_sel    (bus.ch_sel_i[1]),
        .i_step   (bus.ramp_step_i),
        .i_src0   (bus.src0_b_i),
        .i_src1   (bus.src1_b_i),
        .o_dat    (bus.dac_dat_b_o),
        .o_on     (w_on[1]),
        .o_busy   (w_busy[1])
    );

    assign bus.ch_on_o   = w_on;
    assign bus.ch_busy_o = w_busy;

endmodule

// File: tb/tb_red_pitaya_dac_seq.sv
// Bench for the DAC sequencer: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a behavioural model.
module tb_red_pitaya_dac_seq
    import red_pitaya_dac_seq_pkg::*;
;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    red_pitaya_dac_seq_if bus();

    red_pitaya_dac_seq dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst_n),
        .bus       (bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic [1:0] ena,
                                 input logic [1:0] sel, input int step);
        bus.dac_locked_i = lock;
        bus.ch_ena_i     = ena;
        bus.ch_sel_i     = sel;
        bus.ramp_step_i  = 10'(step);
    endtask

    // Behavioural model: gain as a plain integer in 0..1024, output is the
    // floor of src*gain/1024 seen two edges after the gain was set.
    typedef enum int {IDLE, RISE, HOLD, FALL} mode_t;
    mode_t mMode[2] = '{IDLE, IDLE};
    int    mGain[2] = '{0, 0};
    bit    mSel[2]  = '{0, 0};
    int    mX[2]    = '{0, 0};
    int    mG[2]    = '{0, 0};
    int    mOut[2]  = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                mMode[ch] = IDLE; mGain[ch] = 0; mSel[ch] = 0;
                mX[ch] = 0; mG[ch] = 0; mOut[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                int inc, s0, s1;
                bit ena, sel;
                ena = bus.ch_ena_i[ch];
                sel = bus.ch_sel_i[ch];
                s0  = (ch == 0) ? int'(bus.src0_a_i) : int'(bus.src0_b_i);
                s1  = (ch == 0) ? int'(bus.src1_a_i) : int'(bus.src1_b_i);
                inc = (bus.ramp_step_i == 0) ? 1024 : int'(bus.ramp_step_i);
                if (!bus.dac_locked_i) begin
                    mMode[ch] = IDLE; mGain[ch] = 0;
                    mX[ch] = 0; mG[ch] = 0; mOut[ch] = 0;
                end else begin
                    mOut[ch] = (mX[ch] * mG[ch]) >>> 10;
                    mX[ch]   = mSel[ch] ? s1 : s0;
                    mG[ch]   = mGain[ch];
                    if (mMode[ch] == IDLE && ena) mSel[ch] = sel;
                    if ((mMode[ch] == IDLE && ena) ||
                        ((mMode[ch] == RISE || mMode[ch] == HOLD) && ena && sel == mSel[ch])) begin
                        mGain[ch] = (mGain[ch] + inc > 1024) ? 1024 : mGain[ch] + inc;
                        mMode[ch] = (mGain[ch] == 1024) ? HOLD : RISE;
                    end else if (mMode[ch] != IDLE) begin
                        mGain[ch] = (mGain[ch] - inc < 0) ? 0 : mGain[ch] - inc;
                        mMode[ch] = (mGain[ch] == 0) ? IDLE : FALL;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_dat_a", int'(bus.dac_dat_a_o), mOut[0]);
        checkOutput("model_dat_b", int'(bus.dac_dat_b_o), mOut[1]);
        for (int ch = 0; ch < 2; ch++) begin
            checkOutput("model_on", int'(bus.ch_on_o[ch]), (mMode[ch] == HOLD) ? 1 : 0);
            checkOutput("model_busy", int'(bus.ch_busy_o[ch]),
                        (mMode[ch] == RISE || mMode[ch] == FALL) ? 1 : 0);
        end
    end

    int exp2[8] = '{750, 500, 250, 0, -500, -1000, -1500, -2000};
    int lockHold = 0;

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 2'b00, 0);
        bus.src0_a_i = '0; bus.src0_b_i = '0; bus.src1_a_i = '0; bus.src1_b_i = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_dat_a", int'(bus.dac_dat_a_o), 0);
        checkOutput("reset_on", int'(bus.ch_on_o), 0);
        checkOutput("reset_busy", int'(bus.ch_busy_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ramp up from OFF with step 256
        applyStimulus(1'b1, 2'b01, 2'b00, 256);
        bus.src0_a_i = 14'sd1000;
        repeat (3) @(negedge clk);
        checkOutput("t1_dat_e3", int'(bus.dac_dat_a_o), 250);
        checkOutput("t1_on_e3", int'(bus.ch_on_o[0]), 0);
        @(negedge clk);
        checkOutput("t1_dat_e4", int'(bus.dac_dat_a_o), 500);
        checkOutput("t1_on_e4", int'(bus.ch_on_o[0]), 1);
        @(negedge clk);
        checkOutput("t1_dat_e5", int'(bus.dac_dat_a_o), 750);
        @(negedge clk);
        checkOutput("t1_dat_e6", int'(bus.dac_dat_a_o), 1000);

        // Source swap: ramp down on src0, one OFF cycle, ramp up on src1
        bus.src1_a_i = -14'sd2000;
        applyStimulus(1'b1, 2'b01, 2'b01, 256);
        @(negedge clk);
        checkOutput("t2_busy", int'(bus.ch_busy_o[0]), 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_seq%0d", i), int'(bus.dac_dat_a_o), exp2[i]);
        end
        checkOutput("t2_on", int'(bus.ch_on_o[0]), 1);

        // Lock loss in the middle of a ramp-up, then relock
        applyStimulus(1'b1, 2'b00, 2'b01, 256);
        repeat (6) @(negedge clk);
        applyStimulus(1'b1, 2'b01, 2'b01, 256);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 2'b01, 2'b01, 256);
        @(negedge clk);
        checkOutput("t3_lost_dat", int'(bus.dac_dat_a_o), 0);
        checkOutput("t3_lost_busy", int'(bus.ch_busy_o[0]), 0);
        applyStimulus(1'b1, 2'b01, 2'b01, 256);
        @(negedge clk);
        checkOutput("t3_relock_busy", int'(bus.ch_busy_o[0]), 1);
        repeat (2) @(negedge clk);
        checkOutput("t3_relock_dat", int'(bus.dac_dat_a_o), -500);

        // Instant enable/disable with step 0 on channel B
        bus.src0_b_i = 14'sd123;
        applyStimulus(1'b1, 2'b11, 2'b01, 0);
        @(negedge clk);
        checkOutput("t4_on_b", int'(bus.ch_on_o[1]), 1);
        repeat (2) @(negedge clk);
        checkOutput("t4_dat_b", int'(bus.dac_dat_b_o), 123);
        applyStimulus(1'b1, 2'b01, 2'b01, 0);
        @(negedge clk);
        checkOutput("t4_off_b", int'(bus.ch_on_o[1]), 0);
        repeat (2) @(negedge clk);
        checkOutput("t4_dat_b_off", int'(bus.dac_dat_b_o), 0);

        // Full-scale extremes and floor rounding at half gain
        bus.src0_b_i = -14'sd8192;
        applyStimulus(1'b1, 2'b11, 2'b01, 0);
        repeat (3) @(negedge clk);
        checkOutput("t5_neg_full", int'(bus.dac_dat_b_o), -8192);
        bus.src0_b_i = 14'sd8191;
        repeat (2) @(negedge clk);
        checkOutput("t5_pos_full", int'(bus.dac_dat_b_o), 8191);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 2'b10, 2'b00, 512);
            repeat (3) @(negedge clk);
            bus.src0_a_i = (k == 0) ? -14'sd1 : 14'sd1;
            applyStimulus(1'b1, 2'b11, 2'b00, 512);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("t5_half_%0d", k), int'(bus.dac_dat_a_o), (k == 0) ? -1 : 0);
        end

        // Asynchronous reset between edges while channel B is ON
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_dat_b", int'(bus.dac_dat_b_o), 0);
        checkOutput("t6_on", int'(bus.ch_on_o), 0);
        applyStimulus(1'b1, 2'b00, 2'b00, 256);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_idle_on", int'(bus.ch_on_o), 0);
        checkOutput("t6_idle_busy", int'(bus.ch_busy_o), 0);

        // Random phase: slow-changing controls, fast-changing sources
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (lockHold > 0) lockHold--;
            else if ($urandom_range(0, 199) == 0) lockHold = $urandom_range(1, 4);
            bus.dac_locked_i = (lockHold == 0);
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 39) == 0) bus.ch_ena_i[ch] = ~bus.ch_ena_i[ch];
                if ($urandom_range(0, 39) == 0) bus.ch_sel_i[ch] = ~bus.ch_sel_i[ch];
            end
            if ($urandom_range(0, 19) == 0)
                bus.ramp_step_i = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 300));
            bus.src0_a_i = sample_t'($urandom);
            bus.src0_b_i = sample_t'($urandom);
            bus.src1_a_i = sample_t'($urandom);
            bus.src1_b_i = sample_t'($urandom);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
